// File: rtl/regfile_scoreboard.sv
// Register file with two combinational read ports, one write-back port and a
// per-register pending-write scoreboard. Optional bypass: REGFILE_BYPASS_EN.
module regfile_scoreboard #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] ReadReg1,
    input  logic [ADDR_W-1:0] ReadReg2,
    output logic [DATA_W-1:0] ReadData1,
    output logic [DATA_W-1:0] ReadData2,
    output logic              Busy1,
    output logic              Busy2,
    input  logic              IssueValid,
    input  logic [ADDR_W-1:0] IssueReg,
    output logic              IssueReady,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] WriteReg,
    input  logic [DATA_W-1:0] WriteData,
    output logic [ADDR_W:0]   PendingCount
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int CW    = ADDR_W + 1;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DEPTH-1:0]  pend_q;
    logic [DEPTH-1:0]  pend_d;
    logic [CW-1:0]     cnt_q;
    logic [CW-1:0]     cnt_d;

    logic r0_rd1;
    logic r0_rd2;
    logic r0_iss;
    logic r0_wr;
    logic wr_en;
    logic accept;
    logic set_en;
    logic clr_en;

    assign r0_rd1 = (ZERO_REG != 0) && (ReadReg1 == '0);
    assign r0_rd2 = (ZERO_REG != 0) && (ReadReg2 == '0);
    assign r0_iss = (ZERO_REG != 0) && (IssueReg == '0);
    assign r0_wr  = (ZERO_REG != 0) && (WriteReg == '0);

    // Reset also masks the write port so bypass cannot leak data during reset
    assign wr_en = RegWrite & reset & ~r0_wr;

    assign IssueReady = r0_iss | ~pend_q[IssueReg];
    assign accept     = IssueValid & IssueReady & reset;
    assign set_en     = accept & ~r0_iss;
    assign clr_en     = wr_en & pend_q[WriteReg];

    always_comb begin
        ReadData1 = regs_q[ReadReg1];
        Busy1     = pend_q[ReadReg1];
        if (r0_rd1) begin
            ReadData1 = '0;
            Busy1     = 1'b0;
        end
`ifdef REGFILE_BYPASS_EN
        if (wr_en && (WriteReg == ReadReg1)) begin
            ReadData1 = WriteData;
            Busy1     = 1'b0;
        end
`endif
    end

    always_comb begin
        ReadData2 = regs_q[ReadReg2];
        Busy2     = pend_q[ReadReg2];
        if (r0_rd2) begin
            ReadData2 = '0;
            Busy2     = 1'b0;
        end
`ifdef REGFILE_BYPASS_EN
        if (wr_en && (WriteReg == ReadReg2)) begin
            ReadData2 = WriteData;
            Busy2     = 1'b0;
        end
`endif
    end

    // A set and a clear never hit the same bit: issue needs it clear, clear needs it set
    always_comb begin
        pend_d = pend_q;
        if (clr_en) begin
            pend_d[WriteReg] = 1'b0;
        end
        if (set_en) begin
            pend_d[IssueReg] = 1'b1;
        end
        cnt_d = cnt_q + CW'(set_en) - CW'(clr_en);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            pend_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (wr_en) begin
                regs_q[WriteReg] <= WriteData;
            end
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
        end
    end

    assign PendingCount = cnt_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard: directed scenarios plus
// randomized traffic against an array-based reference model.
module tb_regfile_scoreboard;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [AW-1:0] rr1, rr2, ir, wr;
    logic [DW-1:0] wd;
    logic          iv, rw;
    logic [DW-1:0] rd1, rd2;
    logic          b1, b2, irdy;
    logic [AW:0]   pc;

    logic [1:0]    f_rr1, f_rr2, f_ir, f_wr;
    logic [DW-1:0] f_wd, f_rd1, f_rd2;
    logic          f_iv, f_rw, f_b1, f_b2, f_irdy;
    logic [2:0]    f_pc;

    int n_chk = 0;
    int n_fail = 0;

    logic [DW-1:0] m_mem [NR];
    bit            m_pend [NR];

    regfile_scoreboard #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1)) u_dut (
        .clk(clk), .reset(rst_n),
        .ReadReg1(rr1), .ReadReg2(rr2),
        .ReadData1(rd1), .ReadData2(rd2),
        .Busy1(b1), .Busy2(b2),
        .IssueValid(iv), .IssueReg(ir), .IssueReady(irdy),
        .RegWrite(rw), .WriteReg(wr), .WriteData(wd),
        .PendingCount(pc)
    );

    regfile_scoreboard #(.DATA_W(DW), .ADDR_W(2), .ZERO_REG(0)) u_fill (
        .clk(clk), .reset(rst_n),
        .ReadReg1(f_rr1), .ReadReg2(f_rr2),
        .ReadData1(f_rd1), .ReadData2(f_rd2),
        .Busy1(f_b1), .Busy2(f_b2),
        .IssueValid(f_iv), .IssueReg(f_ir), .IssueReady(f_irdy),
        .RegWrite(f_rw), .WriteReg(f_wr), .WriteData(f_wd),
        .PendingCount(f_pc)
    );

    function automatic logic [DW-1:0] m_rd(input logic [AW-1:0] a);
        if (a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
        if (rw && wr == a) return wd;
`endif
        return m_mem[a];
    endfunction

    function automatic logic m_busy(input logic [AW-1:0] a);
        if (a == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
        if (rw && wr == a) return 1'b0;
`endif
        return m_pend[a];
    endfunction

    function automatic logic m_ready(input logic [AW-1:0] a);
        return (a == 0) || !m_pend[a];
    endfunction

    function automatic logic [AW:0] m_count();
        int s = 0;
        for (int i = 0; i < NR; i++) s += int'(m_pend[i]);
        return (AW+1)'(s);
    endfunction

    task automatic m_clear();
        for (int i = 0; i < NR; i++) begin
            m_mem[i] = '0;
            m_pend[i] = 1'b0;
        end
    endtask

    task automatic idle();
        iv = 0; rw = 0; ir = 0; wr = 0; wd = 0;
        f_iv = 0; f_rw = 0; f_ir = 0; f_wr = 0; f_wd = 0;
    endtask

    // Model commits the edge's effects, then time moves to just after the edge
    task automatic tick();
        bit acc;
        acc = iv && m_ready(ir);
        if (rw && wr != 0) begin
            m_mem[wr] = wd;
            m_pend[wr] = 1'b0;
        end
        if (acc && ir != 0) m_pend[ir] = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle();
        rw = 1; wr = 1; wd = 32'h111; tick();
        wr = 2; wd = 32'h222; tick();
        wr = 3; wd = 32'h333; tick();
        rw = 0; iv = 1; ir = 4; tick();
        iv = 0; rr1 = 1; rr2 = 4; ir = 4; #1;
        n_chk++;
        if (rd1 !== m_rd(1) || b2 !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset: rd1=%h b2=%b required %h 1", rd1, b2, m_rd(1));
        end
        #2;
        rst_n = 0;
        rw = 1; wr = 1; wd = 32'hFFFF_FFFF; rr2 = 2;
        #1;
        n_chk++;
        if (rd1 !== 0 || rd2 !== 0) begin
            n_fail++;
            $display("FAIL reset_data: rd1=%h rd2=%h required 0 0", rd1, rd2);
        end
        rr2 = 4; #1;
        n_chk++;
        if (b2 !== 0 || irdy !== 1 || pc !== 0) begin
            n_fail++;
            $display("FAIL reset_sb: b2=%b irdy=%b pc=%0d required 0 1 0", b2, irdy, pc);
        end
        m_clear();
        @(posedge clk); #1;
        n_chk++;
        if (rd1 !== 0 || f_pc !== 0) begin
            n_fail++;
            $display("FAIL reset_ignore: rd1=%h f_pc=%0d required 0 0", rd1, f_pc);
        end
        idle();
        @(negedge clk) rst_n = 1;
        @(posedge clk); #1;
    endtask

    task automatic test_issue_wb();
        idle();
        iv = 1; ir = 5; rr1 = 5; #1;
        n_chk++;
        if (irdy !== 1) begin
            n_fail++;
            $display("FAIL issue_ready: got %b required 1", irdy);
        end
        tick();
        n_chk++;
        if (b1 !== 1 || pc !== 1 || irdy !== 0) begin
            n_fail++;
            $display("FAIL issue_pending: b1=%b pc=%0d irdy=%b required 1 1 0", b1, pc, irdy);
        end
        tick();
        n_chk++;
        if (pc !== 1) begin
            n_fail++;
            $display("FAIL reissue_held: pc=%0d required 1", pc);
        end
        iv = 0; rw = 1; wr = 5; wd = 32'hDEAD_BEEF; tick();
        rw = 0; #1;
        n_chk++;
        if (b1 !== 0 || rd1 !== 32'hDEAD_BEEF || pc !== 0) begin
            n_fail++;
            $display("FAIL writeback: b1=%b rd1=%h pc=%0d required 0 deadbeef 0", b1, rd1, pc);
        end
    endtask

    task automatic test_zero();
        idle();
        rw = 1; wr = 0; wd = 32'h1234_5678;
        iv = 1; ir = 0; rr1 = 0; rr2 = 0; #1;
        n_chk++;
        if (irdy !== 1 || rd1 !== 0) begin
            n_fail++;
            $display("FAIL zero_same: irdy=%b rd1=%h required 1 0", irdy, rd1);
        end
        tick();
        idle(); #1;
        n_chk++;
        if (rd1 !== 0 || rd2 !== 0 || b1 !== 0 || pc !== 0 || irdy !== 1) begin
            n_fail++;
            $display("FAIL zero_reg: rd1=%h b1=%b pc=%0d irdy=%b required 0 0 0 1", rd1, b1, pc, irdy);
        end
    endtask

    task automatic test_same_cycle();
        idle();
        iv = 1; ir = 7; tick();
        rw = 1; wr = 7; wd = 32'h77; #1;
        n_chk++;
        if (irdy !== 0 || pc !== 1) begin
            n_fail++;
            $display("FAIL same_reg_reject: irdy=%b pc=%0d required 0 1", irdy, pc);
        end
        tick();
        rw = 0; #1;
        n_chk++;
        if (pc !== 0 || irdy !== 1) begin
            n_fail++;
            $display("FAIL same_reg_clear: pc=%0d irdy=%b required 0 1", pc, irdy);
        end
        tick();
        n_chk++;
        if (pc !== 1) begin
            n_fail++;
            $display("FAIL same_reg_retry: pc=%0d required 1", pc);
        end
        ir = 9; tick();
        ir = 8; rw = 1; wr = 9; wd = 32'h99; tick();
        idle(); rr1 = 8; rr2 = 9; #1;
        n_chk++;
        if (pc !== 2 || b1 !== 1 || b2 !== 0 || rd2 !== 32'h99) begin
            n_fail++;
            $display("FAIL diff_reg: pc=%0d b1=%b b2=%b rd2=%h required 2 1 0 99", pc, b1, b2, rd2);
        end
    endtask

    task automatic test_bypass();
        idle();
        iv = 1; ir = 3; tick();
        iv = 0; rw = 1; wr = 3; wd = 32'hA5A5_A5A5; rr2 = 3; #1;
        n_chk++;
`ifdef REGFILE_BYPASS_EN
        if (rd2 !== 32'hA5A5_A5A5 || b2 !== 0 || irdy !== 0) begin
            n_fail++;
            $display("FAIL bypass: rd2=%h b2=%b irdy=%b required a5a5a5a5 0 0", rd2, b2, irdy);
        end
`else
        if (rd2 !== 32'h0 || b2 !== 1 || irdy !== 0) begin
            n_fail++;
            $display("FAIL no_bypass: rd2=%h b2=%b irdy=%b required 0 1 0", rd2, b2, irdy);
        end
`endif
        tick();
        rw = 0; #1;
        n_chk++;
        if (rd2 !== 32'hA5A5_A5A5 || b2 !== 0) begin
            n_fail++;
            $display("FAIL bypass_next: rd2=%h b2=%b required a5a5a5a5 0", rd2, b2);
        end
    endtask

    task automatic test_fill();
        idle();
        f_iv = 1;
        for (int r = 0; r < 4; r++) begin
            f_ir = 2'(r); #1;
            n_chk++;
            if (f_irdy !== 1) begin
                n_fail++;
                $display("FAIL fill_ready r%0d: got %b required 1", r, f_irdy);
            end
            tick();
        end
        f_iv = 0; #1;
        n_chk++;
        if (f_pc !== 4) begin
            n_fail++;
            $display("FAIL fill_count: got %0d required 4", f_pc);
        end
        for (int r = 0; r < 4; r++) begin
            f_ir = 2'(r); #1;
            n_chk++;
            if (f_irdy !== 0) begin
                n_fail++;
                $display("FAIL fill_full r%0d: got %b required 0", r, f_irdy);
            end
        end
        f_rw = 1;
        for (int r = 0; r < 4; r++) begin
            f_wr = 2'(r); f_wd = 32'h200 + r; tick();
        end
        f_rw = 0; f_rr1 = 0; f_rr2 = 2; #1;
        n_chk++;
        if (f_pc !== 0 || f_rd1 !== 32'h200 || f_rd2 !== 32'h202 || f_b1 !== 0) begin
            n_fail++;
            $display("FAIL fill_drain: pc=%0d rd1=%h rd2=%h b1=%b required 0 200 202 0", f_pc, f_rd1, f_rd2, f_b1);
        end
    endtask

    task automatic test_random();
        idle();
        for (int n = 0; n < 300; n++) begin
            iv  = 1'($urandom_range(0, 1));
            ir  = AW'($urandom_range(0, 9));
            rw  = 1'($urandom_range(0, 1));
            wr  = AW'($urandom_range(0, 9));
            wd  = $urandom;
            rr1 = ($urandom_range(0, 3) == 0) ? wr : AW'($urandom_range(0, 9));
            rr2 = AW'($urandom_range(0, 31));
            #1;
            n_chk++;
            if (rd1 !== m_rd(rr1) || rd2 !== m_rd(rr2) || b1 !== m_busy(rr1) ||
                b2 !== m_busy(rr2) || irdy !== m_ready(ir) || pc !== m_count()) begin
                n_fail++;
                $display("FAIL random #%0d: rd1=%h rd2=%h b1=%b b2=%b irdy=%b pc=%0d required %h %h %b %b %b %0d",
                         n, rd1, rd2, b1, b2, irdy, pc, m_rd(rr1), m_rd(rr2),
                         m_busy(rr1), m_busy(rr2), m_ready(ir), m_count());
            end
            tick();
        end
        idle();
    endtask

    initial begin
        m_clear();
        idle();
        rr1 = 0; rr2 = 0; f_rr1 = 0; f_rr2 = 0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1;
        @(posedge clk); #1;
        test_reset();
        test_issue_wb();
        test_zero();
        test_same_cycle();
        test_bypass();
        test_fill();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
